a_skew_buffer: RTL
==================

# a_skew_buffer

Parametrised activation buffer for the systolic array. It holds activation rows in an internal single-clock RAM and, on a start command, streams a programmable number of rows from a strided address sequence. Each lane is skewed by its index so the rows enter the ARRAY_N-wide input edge of the array as a diagonal wavefront. It adds a host write port, lane masking, address stride, backpressure (stall) and busy/done status.

## Interface
- RAM_SIZE, 1<<16: number of RAM words; each word is one full row of ARRAY_N activations.
- ADDR_WIDTH, $clog2(RAM_SIZE): RAM address width.
- ARRAY_N, 8: lanes, i.e. activations per row and array input rows.
- ACT_WIDTH, 8: bits per activation.
- MAX_ROWS, 256: maximum rows per command.
- IBUF_DATA_WIDTH, ARRAY_N*ACT_WIDTH: row/word width; lane i occupies bits [i*ACT_WIDTH +: ACT_WIDTH].

Ports:
- clk  in  1  Single clock; all logic is on its rising edge.
- reset  in  1  Asynchronous, active-low reset.
- wr_en  in  1  Host write strobe.
- wr_addr  in  ADDR_WIDTH  Host write address.
- wr_data  in  IBUF_DATA_WIDTH  Host write row.
- start  in  1  Command pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  First row address.
- stride  in  ADDR_WIDTH  Address increment between rows.
- num_rows  in  $clog2(MAX_ROWS)+1  Rows to stream.
- num_lanes  in  $clog2(ARRAY_N)+1  Active lanes, 0..ARRAY_N; values above ARRAY_N are treated as ARRAY_N.
- stall  in  1  Freezes the whole read/skew pipeline while high.
- act_data_set_out  out  IBUF_DATA_WIDTH  Skewed activations.
- act_valid  out  ARRAY_N  Per-lane valid.
- busy  out  1  Command in progress.
- done  out  1  One-cycle completion pulse.

## Operation
- Command registers (base_addr, stride, num_rows, num_lanes) are captured when start=1 in IDLE. start outside IDLE is ignored.
- FSM states:
  - IDLE: start with num_rows>0 goes to READ. start with num_rows=0 goes to DONE with no RAM reads.
  - READ: issues one RAM read per unstalled cycle at base_addr + k*stride, for k=0..num_rows-1. The address wraps modulo RAM_SIZE (ADDR_WIDTH truncation). After the last read, go to DRAIN.
  - DRAIN: counts ARRAY_N unstalled cycles to flush the RAM latency and the skew chain, then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- RAM read latency is 1 cycle. Read data is registered into lane 0 of the skew chain. Lane i passes through i further register stages, so lane i carries row k exactly i cycles after lane 0.
- Lane masking: lanes >= num_lanes output zero and have act_valid low. Only lanes < num_lanes carry data and have act_valid high.
- Outputs: act_valid[i] is high only while lane i carries a real row. At all other times the lane data is zero.
- Stall: while stall=1, the FSM, address counter, RAM read enable, skew registers and outputs all hold. No row is lost or duplicated.
- Write port: independent of the FSM and usable in any state. A write and a read to the same address in the same cycle return the old data (read-first).
- Reset: reset low at any time, including mid-command, immediately forces IDLE. All outputs go to 0 and the skew registers clear. RAM contents are not cleared.

## Timing
- Reset values: act_data_set_out=0, act_valid=0, busy=0, done=0.
- Cycle numbering is relative to the edge where start is sampled (cycle 0), with no stall:
  - busy rises in cycle 1.
  - Read k is issued in cycle 1+k.
  - Lane i outputs row k in cycle 2+k+i.
  - The last valid output is lane ARRAY_N-1 at cycle num_rows+ARRAY_N.
  - done is high in cycle num_rows+ARRAY_N+1; busy falls in the same cycle.
  - A new start is accepted from cycle num_rows+ARRAY_N+2.
- num_rows=0: busy=1 in cycle 1 only, done=1 in cycle 1, no act_valid.
- Each stall cycle shifts every later event by exactly one cycle.
- A write in cycle c is visible to reads issued in cycle c+1 or later.

## Test plan
- Basic stream: write rows 16..19 with lane i of row r = r*16+i. Command base_addr=16, stride=1, num_rows=4, num_lanes=8 -> lane 0 valid in cycles 2-5 with values 0x00,0x10,0x20,0x30 (low byte); lane 7 valid in cycles 9-12; done in cycle 13.
- Stride and wrap: base_addr=65534, stride=3, num_rows=3 -> reads at addresses 65534, 1, 4.
- Lane mask: num_lanes=3 -> lanes 3-7 stay 0 with act_valid low for the whole command; lanes 0-2 match the basic-stream timing.
- Stall: assert stall for 2 cycles starting at cycle 4 of the basic stream -> every event from cycle 4 onward is shifted by 2, data is identical, and done arrives in cycle 15.
- Edge commands: num_rows=0 -> done in cycle 1 with no valids. A start during busy -> ignored, and the original command completes unchanged.
- Reset mid-command: pull reset low in cycle 6 -> all outputs are 0 immediately. After release, a fresh command runs with correct timing and the RAM data is intact.

Source files
------------

// File: rtl/a_skew_buffer_if.sv
// a_skew_buffer_if: host write port, stream command, flow control and skewed
// activation output of the activation skew buffer.
interface a_skew_buffer_if #(
  parameter int RAM_SIZE        = 32'd1 << 16,
  parameter int ADDR_WIDTH      = $clog2(RAM_SIZE),
  parameter int ARRAY_N         = 8,
  parameter int ACT_WIDTH       = 8,
  parameter int MAX_ROWS        = 256,
  parameter int IBUF_DATA_WIDTH = ARRAY_N * ACT_WIDTH
);
  localparam int ROWS_W  = $clog2(MAX_ROWS) + 1;
  localparam int LANES_W = $clog2(ARRAY_N) + 1;

  logic                       wr_en;
  logic [ADDR_WIDTH-1:0]      wr_addr;
  logic [IBUF_DATA_WIDTH-1:0] wr_data;
  logic                       start;
  logic [ADDR_WIDTH-1:0]      base_addr;
  logic [ADDR_WIDTH-1:0]      stride;
  logic [ROWS_W-1:0]          num_rows;
  logic [LANES_W-1:0]         num_lanes;
  logic                       stall;
  logic [IBUF_DATA_WIDTH-1:0] act_data_set_out;
  logic [ARRAY_N-1:0]         act_valid;
  logic                       busy;
  logic                       done;

  modport master (
    output wr_en, wr_addr, wr_data, start, base_addr, stride, num_rows, num_lanes, stall,
    input  act_data_set_out, act_valid, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, base_addr, stride, num_rows, num_lanes, stall,
    output act_data_set_out, act_valid, busy, done
  );
endinterface

// File: rtl/a_skew_buffer.sv
// a_skew_buffer: activation row RAM that streams a strided run of rows into the
// systolic array, delaying lane i by i cycles to form a diagonal wavefront.
module a_skew_buffer #(
  parameter int RAM_SIZE        = 32'd1 << 16,
  parameter int ADDR_WIDTH      = $clog2(RAM_SIZE),
  parameter int ARRAY_N         = 8,
  parameter int ACT_WIDTH       = 8,
  parameter int MAX_ROWS        = 256,
  parameter int IBUF_DATA_WIDTH = ARRAY_N * ACT_WIDTH
) (
  input logic            clk,
  input logic            reset,
  a_skew_buffer_if.slave bus
);
  localparam int ROWS_W  = $clog2(MAX_ROWS) + 1;
  localparam int LANES_W = $clog2(ARRAY_N) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [IBUF_DATA_WIDTH-1:0] mem [RAM_SIZE];

  logic [1:0]                 state_r;
  logic [1:0]                 next_state_s;
  logic [ADDR_WIDTH-1:0]      addr_r;
  logic [ADDR_WIDTH-1:0]      stride_r;
  logic [ROWS_W-1:0]          rows_left_r;
  logic [LANES_W-1:0]         drain_cnt_r;
  logic [ARRAY_N-1:0]         lane_en_r;
  logic                       busy_r;
  logic                       done_r;
  logic                       rd_en_s;
  logic [IBUF_DATA_WIDTH-1:0] rd_word_s;
  logic [IBUF_DATA_WIDTH-1:0] act_data_s;
  logic [ARRAY_N-1:0]         act_valid_s;

  // Requested lane count saturates at the array width.
  function automatic logic [ARRAY_N-1:0] lane_mask(input logic [LANES_W-1:0] lanes);
    logic [ARRAY_N-1:0] mask_v;
    if (lanes >= LANES_W'(ARRAY_N)) begin
      mask_v = '1;
    end else begin
      mask_v = (ARRAY_N'(1'b1) << lanes) - ARRAY_N'(1'b1);
    end
    return mask_v;
  endfunction

  // Host write port: runs in every state; the read below sees the pre-write word.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign rd_en_s   = (state_r == ST_READ) && !bus.stall;
  assign rd_word_s = mem[addr_r];

  // Next-state logic; a stalled cycle leaves the sequencer where it is.
  always_comb begin
    next_state_s = state_r;
    if (bus.stall) begin
      next_state_s = state_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            next_state_s = (bus.num_rows == '0) ? ST_DONE : ST_READ;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_READ: begin
          if (rows_left_r == ROWS_W'(1'b1)) begin
            next_state_s = ST_DRAIN;
          end else begin
            next_state_s = ST_READ;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == LANES_W'(ARRAY_N - 1)) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_DRAIN;
          end
        end
        ST_DONE:  next_state_s = ST_IDLE;
        default:  next_state_s = ST_IDLE;
      endcase
    end
  end

  // Sequencer, command capture, address walk and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      stride_r    <= '0;
      rows_left_r <= '0;
      drain_cnt_r <= '0;
      lane_en_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else if (!bus.stall) begin
      state_r <= next_state_s;
      // A zero-row command reports busy for its single DONE cycle.
      busy_r  <= (next_state_s == ST_READ) || (next_state_s == ST_DRAIN) ||
                 ((next_state_s == ST_DONE) && (state_r == ST_IDLE));
      done_r  <= (next_state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            addr_r      <= bus.base_addr;
            stride_r    <= bus.stride;
            rows_left_r <= bus.num_rows;
            lane_en_r   <= lane_mask(bus.num_lanes);
            drain_cnt_r <= '0;
          end
        end
        ST_READ: begin
          addr_r      <= addr_r + stride_r;
          rows_left_r <= rows_left_r - ROWS_W'(1'b1);
        end
        ST_DRAIN: begin
          drain_cnt_r <= drain_cnt_r + LANES_W'(1'b1);
        end
        default: begin
          drain_cnt_r <= drain_cnt_r;
        end
      endcase
    end
  end

  for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
    localparam int PIPE_W = (i + 1) * ACT_WIDTH;
    localparam int VLD_W  = i + 1;

    logic [ACT_WIDTH-1:0] lane_in_s;
    logic                 lane_vld_s;
    logic [PIPE_W-1:0]    pipe_r;
    logic [VLD_W-1:0]     vld_r;

    assign lane_vld_s = rd_en_s && lane_en_r[i];
    assign lane_in_s  = lane_vld_s ? rd_word_s[i*ACT_WIDTH +: ACT_WIDTH] : '0;

    // Lane i: stage 0 is the RAM output register, then i more delay stages.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pipe_r <= '0;
        vld_r  <= '0;
      end else if (!bus.stall) begin
        pipe_r <= (pipe_r << ACT_WIDTH) | PIPE_W'(lane_in_s);
        vld_r  <= (vld_r << 1'b1) | VLD_W'(lane_vld_s);
      end
    end

    assign act_data_s[i*ACT_WIDTH +: ACT_WIDTH] = pipe_r[PIPE_W-1 -: ACT_WIDTH];
    assign act_valid_s[i]                       = vld_r[VLD_W-1];
  end

  assign bus.act_data_set_out = act_data_s;
  assign bus.act_valid        = act_valid_s;
  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
endmodule
